// File: rtl/rep_iter_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rep_iter_sched_if : stage-side and iteration-side signals of the REP       |
// | sequencer. Revision: 1.0                                                   |
// +----------------------------------------------------------------------------+
interface rep_iter_sched_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              start;
  logic [CNT_W-1:0]  count_in;
  logic              addr16;
  logic [ADDR_W-1:0] mem1_in;
  logic [ADDR_W-1:0] mem2_in;
  logic [1:0]        opsize;
  logic              dflag;
  logic              abort;
  logic              iter_ready;
  logic              iter_valid;
  logic [ADDR_W-1:0] mem_addr1;
  logic [ADDR_W-1:0] mem_addr2;
  logic              iter_last;
  logic              rep_stall;
  logic              using_regs;
  logic              cnt_wb_valid;
  logic [CNT_W-1:0]  cnt_wb;
  logic [CNT_W-1:0]  remaining;

  modport slave (
    input  start, count_in, addr16, mem1_in, mem2_in, opsize, dflag, abort, iter_ready,
    output iter_valid, mem_addr1, mem_addr2, iter_last, rep_stall, using_regs,
           cnt_wb_valid, cnt_wb, remaining
  );

  modport master (
    output start, count_in, addr16, mem1_in, mem2_in, opsize, dflag, abort, iter_ready,
    input  iter_valid, mem_addr1, mem_addr2, iter_last, rep_stall, using_regs,
           cnt_wb_valid, cnt_wb, remaining
  );
endinterface
`default_nettype wire

// File: rtl/rep_iter_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rep_iter_sched : issues one memory iteration per handshake for a REP       |
// | string instruction and returns the final count. Revision: 1.0              |
// +----------------------------------------------------------------------------+
module rep_iter_sched #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  wire logic         clk,
  input  wire logic         clr,
  rep_iter_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;
  logic [1:0]        opsize_q, opsize_d;
  logic              dflag_q, dflag_d;

  logic [CNT_W-1:0]  eff_cnt;
  logic              cnt_nz;
  logic [ADDR_W-1:0] step;

  logic              iter_valid_w;
  logic              iter_last_w;
  logic              rep_stall_w;
  logic              using_regs_w;
  logic              cnt_wb_valid_w;

  // 16-bit addressing uses CX, so the upper count bits are ignored
  assign eff_cnt = bus.addr16 ? {{(CNT_W-16){1'b0}}, bus.count_in[15:0]} : bus.count_in;
  assign cnt_nz  = |eff_cnt;
  assign step    = ADDR_W'(1) << opsize_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      opsize_q <= 2'b00;
      dflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      opsize_q <= opsize_d;
      dflag_q  <= dflag_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr1_d        = addr1_q;
    addr2_d        = addr2_q;
    opsize_d       = opsize_q;
    dflag_d        = dflag_q;
    iter_valid_w   = 1'b0;
    iter_last_w    = 1'b0;
    rep_stall_w    = 1'b0;
    using_regs_w   = 1'b0;
    cnt_wb_valid_w = 1'b0;

    case (state_q)
      S_IDLE: begin
        rep_stall_w = bus.start & cnt_nz & ~clr;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.start) begin
          if (cnt_nz) begin
            cnt_d    = eff_cnt;
            addr1_d  = bus.mem1_in;
            addr2_d  = bus.mem2_in;
            opsize_d = bus.opsize;
            dflag_d  = bus.dflag;
            state_d  = S_ISSUE;
          end else begin
            state_d  = S_DONE;
          end
        end
      end

      S_ISSUE: begin
        iter_valid_w = 1'b1;
        iter_last_w  = (cnt_q == CNT_W'(1));
        rep_stall_w  = 1'b1;
        using_regs_w = 1'b1;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.iter_ready) begin
          cnt_d   = cnt_q - CNT_W'(1);
          addr1_d = dflag_q ? (addr1_q - step) : (addr1_q + step);
          addr2_d = dflag_q ? (addr2_q - step) : (addr2_q + step);
          if (iter_last_w) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        cnt_wb_valid_w = ~bus.abort;
        state_d        = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.iter_valid   = iter_valid_w;
  assign bus.iter_last    = iter_last_w;
  assign bus.rep_stall    = rep_stall_w;
  assign bus.using_regs   = using_regs_w;
  assign bus.cnt_wb_valid = cnt_wb_valid_w;
  assign bus.cnt_wb       = '0;
  assign bus.mem_addr1    = addr1_q;
  assign bus.mem_addr2    = addr2_q;
  assign bus.remaining    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rep_iter_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rep_iter_sched : directed and randomized REP sequences checked against  |
// | an arithmetic reference of the iteration addresses. Revision: 1.0          |
// +----------------------------------------------------------------------------+
module tb_rep_iter_sched;

  localparam int AW = 32;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic clr;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  rep_iter_sched_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  rep_iter_sched #(.ADDR_W(AW), .CNT_W(CW)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic scramble_fields();
    bus.count_in = $urandom;
    bus.addr16   = 1'($urandom_range(0, 1));
    bus.mem1_in  = $urandom;
    bus.mem2_in  = $urandom;
    bus.opsize   = 2'($urandom_range(0, 3));
    bus.dflag    = 1'($urandom_range(0, 1));
  endtask

  // Reference: iteration k of n sits at base +/- k*2^opsize; remaining is n-k.
  task automatic run_rep(input logic [31:0] cnt, input logic a16, input logic [1:0] osz,
                         input logic df, input logic [31:0] m1, input logic [31:0] m2,
                         input logic [31:0] rpat, input int rlen, input int abort_at);
    int          n;
    int          k;
    int          cyc;
    bit          done;
    bit          fire;
    bit          ab;
    logic [31:0] off;
    logic [31:0] cnt16;

    cnt16 = {16'h0000, cnt[15:0]};
    n = a16 ? int'(cnt16) : int'(cnt);
    bus.start      = 1'b1;
    bus.count_in   = cnt;
    bus.addr16     = a16;
    bus.opsize     = osz;
    bus.dflag      = df;
    bus.mem1_in    = m1;
    bus.mem2_in    = m2;
    bus.abort      = 1'b0;
    bus.iter_ready = 1'($urandom_range(0, 1));
    #2;
    check1("idle_stall", bus.rep_stall, n != 0);
    check1("idle_valid", bus.iter_valid, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble_fields();

    if (n == 0) begin
      #2;
      check1("zc_wb_valid", bus.cnt_wb_valid, 1'b1);
      check32("zc_wb", bus.cnt_wb, 32'h0);
      check1("zc_stall", bus.rep_stall, 1'b0);
      check1("zc_valid", bus.iter_valid, 1'b0);
      @(posedge clk); #1; #2;
      check1("zc_wb_after", bus.cnt_wb_valid, 1'b0);
      return;
    end

    k = 0;
    cyc = 0;
    done = 1'b0;
    while (!done) begin
      if (cyc < rlen) bus.iter_ready = rpat[cyc];
      else if (cyc > 40) bus.iter_ready = 1'b1;
      else bus.iter_ready = ($urandom_range(0, 3) != 0);
      bus.abort = (cyc == abort_at);
      bus.start = 1'($urandom_range(0, 1));
      scramble_fields();
      off = 32'(k) << osz;
      #2;
      check1("iss_valid", bus.iter_valid, 1'b1);
      check32("iss_addr1", bus.mem_addr1, df ? (m1 - off) : (m1 + off));
      check32("iss_addr2", bus.mem_addr2, df ? (m2 - off) : (m2 + off));
      check1("iss_last", bus.iter_last, (n - k) == 1);
      check32("iss_remaining", bus.remaining, 32'(n - k));
      check1("iss_stall", bus.rep_stall, 1'b1);
      check1("iss_using_regs", bus.using_regs, 1'b1);
      check1("iss_wb_valid", bus.cnt_wb_valid, 1'b0);
      fire = bus.iter_ready;
      ab   = bus.abort;
      @(posedge clk); #1;
      if (ab) begin
        bus.abort = 1'b0;
        bus.start = 1'b0;
        bus.iter_ready = 1'b0;
        #2;
        check1("abort_valid", bus.iter_valid, 1'b0);
        check1("abort_wb", bus.cnt_wb_valid, 1'b0);
        @(posedge clk); #1; #2;
        check1("abort_wb_later", bus.cnt_wb_valid, 1'b0);
        check1("abort_valid_later", bus.iter_valid, 1'b0);
        done = 1'b1;
      end else begin
        if (fire) k++;
        if (k == n) begin
          bus.start = 1'($urandom_range(0, 1));
          bus.iter_ready = 1'($urandom_range(0, 1));
          scramble_fields();
          #2;
          check1("done_wb_valid", bus.cnt_wb_valid, 1'b1);
          check32("done_wb", bus.cnt_wb, 32'h0);
          check1("done_stall", bus.rep_stall, 1'b0);
          check1("done_valid", bus.iter_valid, 1'b0);
          check1("done_using_regs", bus.using_regs, 1'b0);
          @(posedge clk); #1;
          bus.start = 1'b0;
          #2;
          check1("post_valid", bus.iter_valid, 1'b0);
          check1("post_wb_valid", bus.cnt_wb_valid, 1'b0);
          done = 1'b1;
        end
      end
      cyc++;
      if (!done && cyc > 200) begin
        check1("timeout", 1'b0, 1'b1);
        done = 1'b1;
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.iter_ready = 1'b0;
    bus.count_in = '0;
    bus.addr16 = 1'b0;
    bus.mem1_in = '0;
    bus.mem2_in = '0;
    bus.opsize = 2'b00;
    bus.dflag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_valid", bus.iter_valid, 1'b0);
    check1("rst_stall", bus.rep_stall, 1'b0);
    check1("rst_wb_valid", bus.cnt_wb_valid, 1'b0);
    check32("rst_addr1", bus.mem_addr1, 32'h0);
    check32("rst_remaining", bus.remaining, 32'h0);
    clr = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_rep(32'd3, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h2000, 32'hFFFF_FFFF, 32, -1);
    run_rep(32'd0, 1'b0, 2'b01, 1'b0, 32'h1234, 32'h5678, 32'hFFFF_FFFF, 32, -1);
    run_rep(32'hFFFF_0002, 1'b1, 2'b00, 1'b1, 32'h0001, 32'h0100, 32'hFFFF_FFFF, 32, -1);
    run_rep(32'd4, 1'b0, 2'b00, 1'b0, 32'h0040, 32'h0080, 32'h0000_0039, 6, -1);
    run_rep(32'd5, 1'b0, 2'b01, 1'b0, 32'h0300, 32'h0400, 32'hFFFF_FFFF, 32, 1);
    run_rep(32'd2, 1'b0, 2'b01, 1'b1, 32'h0300, 32'h0400, 32'hFFFF_FFFF, 32, -1);
    run_rep(32'd2, 1'b0, 2'b11, 1'b1, 32'h0000_0004, 32'h0000_0010, 32'hFFFF_FFFF, 32, -1);

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      logic [31:0] rc;
      logic        ra16;
      int          rab;
      ra16 = 1'($urandom_range(0, 1));
      rc   = ra16 ? {$urandom_range(0, 65535) * 32'h0001_0000} | 32'($urandom_range(0, 6))
                  : 32'($urandom_range(0, 6));
      rab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      run_rep(rc, ra16, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, 32'h0, 0, rab);
    end

    // Asynchronous clear in the middle of ISSUE
    bus.start = 1'b1;
    bus.count_in = 32'd3;
    bus.addr16 = 1'b0;
    bus.opsize = 2'b11;
    bus.dflag = 1'b1;
    bus.mem1_in = 32'h0000_0004;
    bus.mem2_in = 32'h0000_0008;
    bus.iter_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check32("wrap_addr1", bus.mem_addr1, 32'hFFFF_FFFC);
    check1("wrap_valid", bus.iter_valid, 1'b1);
    clr = 1'b1;
    #1;
    check1("clr_valid", bus.iter_valid, 1'b0);
    check1("clr_stall", bus.rep_stall, 1'b0);
    check1("clr_last", bus.iter_last, 1'b0);
    check1("clr_using_regs", bus.using_regs, 1'b0);
    check1("clr_wb_valid", bus.cnt_wb_valid, 1'b0);
    check32("clr_addr1", bus.mem_addr1, 32'h0);
    check32("clr_addr2", bus.mem_addr2, 32'h0);
    check32("clr_remaining", bus.remaining, 32'h0);
    check32("clr_wb", bus.cnt_wb, 32'h0);
    #2;
    clr = 1'b0;
    bus.iter_ready = 1'b0;
    @(posedge clk); #1;
    run_rep(32'd1, 1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFFF, 32, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rep_iter_sched.md
Name: rep_iter_sched

Overview:
Sequencer for REP-prefixed string instructions in the register-read/address-generation stage. It captures the count register (ECX/CX) and the two segment-relocated memory addresses when a REP instruction is accepted. It then issues one memory iteration per downstream handshake, stepping the addresses by operand size in the direction-flag sense. It holds the stage stall until the last iteration is accepted, then returns the final count for register writeback.

Parameters:
ADDR_W, 32, width of memory addresses
CNT_W, 32, width of the count register

Ports:
clk  in  1  clock
clr  in  1  reset, asynchronous, active-high
start  in  1  REP instruction valid in stage, all other stalls clear
count_in  in  CNT_W  count register value read from regfile
addr16  in  1  1 = 16b addressing, so only count_in[15:0] is used
mem1_in  in  ADDR_W  source/first address (segbase + offset)
mem2_in  in  ADDR_W  destination/second address
opsize  in  2  element size: 00=1B, 01=2B, 10=4B, 11=8B
dflag  in  1  direction flag: 0 = increment, 1 = decrement
abort  in  1  pipeline flush (mispredict/exception)
iter_ready  in  1  downstream accepts current iteration
iter_valid  out  1  iteration addresses valid
mem_addr1  out  ADDR_W  current first address
mem_addr2  out  ADDR_W  current second address
iter_last  out  1  current iteration is the final one
rep_stall  out  1  hold upstream stage
using_regs  out  1  addresses/count come from the sequencer, not from the regfile
cnt_wb_valid  out  1  one-cycle pulse: final count ready for writeback
cnt_wb  out  CNT_W  final count value (always 0 on completion)
remaining  out  CNT_W  iterations left, including the current one

Behaviour:
- States: IDLE, ISSUE, DONE. On clr, all state goes to IDLE, all registers to 0, and every output to 0.
- eff_cnt = addr16 ? {0, count_in[15:0]} : count_in. step = 1 << opsize.
- IDLE:
  - If start and eff_cnt == 0: go to DONE. No iteration is issued; cnt_wb = 0.
  - If start and eff_cnt != 0: latch eff_cnt, mem1_in, mem2_in, opsize, dflag; go to ISSUE.
  - rep_stall = start & (eff_cnt != 0) combinationally in this cycle.
- ISSUE:
  - iter_valid = 1. mem_addr1/2 = the latched addresses. iter_last = (remaining == 1). rep_stall = 1. using_regs = 1.
  - On iter_ready:
    - remaining -= 1.
    - Both addresses += step when dflag = 0, or -= step when dflag = 1. Arithmetic is modulo 2^ADDR_W; wrap-around is allowed, with no exception raised here.
    - If iter_last, go to DONE.
  - Without iter_ready, all values hold.
  - Latched opsize and dflag are immune to input changes while in ISSUE.
- DONE, held for exactly one cycle:
  - cnt_wb_valid = 1, cnt_wb = 0, rep_stall = 0, iter_valid = 0. Go to IDLE.
  - A start seen in DONE is ignored; upstream re-presents it in IDLE.
- abort in any state: next state is IDLE, iter_valid drops on the next edge, and no cnt_wb_valid is produced. abort has priority over iter_ready and start in the same cycle.
- Latency: the first iteration is valid one cycle after start. N iterations with iter_ready held high take N cycles in ISSUE plus 1 cycle in DONE.
- In IDLE and DONE, mem_addr1/2 show the last registered values. They are don't-care while iter_valid = 0.

Test Plan:
- count_in=3, opsize=10, dflag=0, mem1=0x1000, mem2=0x2000, iter_ready=1 -> iter_valid for 3 cycles with mem_addr1 = 0x1000, 0x1004, 0x1008 and mem_addr2 = 0x2000, 0x2004, 0x2008; iter_last on the 3rd; cnt_wb_valid the next cycle with cnt_wb=0; rep_stall low in DONE.
- count_in=0 with start -> no iter_valid; rep_stall stays 0; cnt_wb_valid one cycle later.
- addr16=1, count_in=0xFFFF0002, opsize=00, dflag=1, mem1=0x0001 -> exactly 2 iterations, mem_addr1 = 0x0001 then 0x0000.
- count 4, iter_ready pattern 1,0,0,1,1,1 -> addresses advance only on ready cycles; remaining goes 4,3,3,3,2,1; completion on the 6th cycle.
- abort asserted during the 2nd iteration of count=5 -> IDLE next cycle, no cnt_wb_valid; a following start behaves as fresh.
- dflag=1, opsize=11, mem1=0x4 -> the second address is 0xFFFFFFFC (wrap-around); clr asserted mid-ISSUE -> all outputs 0 immediately.
